// File: rtl/instruction_loader.sv
// Write-side master that streams a program into the 128x32 instruction memory over valid/ready.
// Optional read-back checksum verify pass is built when LOADER_VERIFY_EN is defined.
module instruction_loader #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128
) (
  input  logic                  clk,
  input  logic                  rst_all,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = (ADDR_WIDTH+1)'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = (ADDR_WIDTH)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = (ADDR_WIDTH)'(0);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = (DATA_WIDTH)'(0);

  // Running XOR checksum shared by the load and verify passes
  function automatic logic [DATA_WIDTH-1:0] xor_accum(input logic [DATA_WIDTH-1:0] acc,
                                                      input logic [DATA_WIDTH-1:0] word);
    return acc ^ word;
  endfunction

  state_t                  state_r;
  state_t                  next_s;
  logic [ADDR_WIDTH:0]     count_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   checksum_r;
  logic                    in_ready_r;
  logic                    we_r;
  logic [ADDR_WIDTH-1:0]   write_addr_r;
  logic [DATA_WIDTH-1:0]   write_data_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    error_r;
  logic                    transfer_s;
  logic                    last_s;
  logic                    count_ok_s;
  logic                    rlast_s;
  logic                    verify_fail_s;

  assign transfer_s = in_valid & in_ready_r;
  assign last_s     = ({1'b0, addr_r} == (count_r - CNT_ONE));
  assign count_ok_s = (word_count != CNT_ZERO) && (word_count <= DEPTH_W);

`ifdef LOADER_VERIFY_EN
  logic [ADDR_WIDTH-1:0] read_addr_r;
  logic [DATA_WIDTH-1:0] vacc_r;

  assign rlast_s       = (state_r == ST_VERIFY) && ({1'b0, read_addr_r} == (count_r - CNT_ONE));
  assign verify_fail_s = rlast_s && (xor_accum(vacc_r, read_data) != checksum_r);
  assign read_addr     = read_addr_r;

  // Verify pass: walk read_addr across the loaded range and fold read_data
  always_ff @(posedge clk or negedge rst_all) begin
    if (!rst_all) begin
      read_addr_r <= ADDR_ZERO;
      vacc_r      <= DATA_ZERO;
    end else if (state_r == ST_VERIFY) begin
      vacc_r      <= xor_accum(vacc_r, read_data);
      read_addr_r <= rlast_s ? ADDR_ZERO : (read_addr_r + ADDR_ONE);
    end else begin
      read_addr_r <= ADDR_ZERO;
      vacc_r      <= DATA_ZERO;
    end
  end
`else
  logic unused_read_s;

  assign unused_read_s = ^read_data;
  assign rlast_s       = 1'b0;
  assign verify_fail_s = 1'b0;
  assign read_addr     = ADDR_ZERO;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_all) begin
    if (!rst_all) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_s = count_ok_s ? ST_LOAD : ST_DONE;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (transfer_s && last_s) begin
          next_s = ST_FLUSH;
        end else begin
          next_s = ST_LOAD;
        end
      end
      ST_FLUSH: begin
`ifdef LOADER_VERIFY_EN
        next_s = ST_VERIFY;
`else
        next_s = ST_DONE;
`endif
      end
      ST_VERIFY: begin
        if (rlast_s) begin
          next_s = ST_DONE;
        end else begin
          next_s = ST_VERIFY;
        end
      end
      ST_DONE: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs; status flags are decoded from the upcoming state
  always_ff @(posedge clk or negedge rst_all) begin
    if (!rst_all) begin
      count_r      <= CNT_ZERO;
      addr_r       <= ADDR_ZERO;
      checksum_r   <= DATA_ZERO;
      in_ready_r   <= 1'b0;
      we_r         <= 1'b0;
      write_addr_r <= ADDR_ZERO;
      write_data_r <= DATA_ZERO;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      in_ready_r <= (next_s == ST_LOAD);
      busy_r     <= (next_s == ST_LOAD) || (next_s == ST_FLUSH) || (next_s == ST_VERIFY);
      done_r     <= (next_s == ST_DONE);
      we_r       <= transfer_s;
      if (transfer_s) begin
        write_addr_r <= addr_r;
        write_data_r <= in_data;
        addr_r       <= addr_r + ADDR_ONE;
        checksum_r   <= xor_accum(checksum_r, in_data);
      end
      if ((state_r == ST_IDLE) && start) begin
        if (count_ok_s) begin
          count_r    <= word_count;
          addr_r     <= ADDR_ZERO;
          checksum_r <= DATA_ZERO;
          error_r    <= 1'b0;
        end else begin
          error_r <= 1'b1;
        end
      end else if (verify_fail_s) begin
        error_r <= 1'b1;
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign we         = we_r;
  assign write_addr = write_addr_r;
  assign write_data = write_data_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: expected writes/done events are queued by the
// stimulus and popped by an independent monitor; includes a 128x32 memory model.
module tb_instruction_loader;

  logic        clk;
  logic        rst_all;
  logic        start;
  logic [7:0]  word_count;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        we;
  logic [6:0]  write_addr;
  logic [31:0] write_data;
  logic [6:0]  read_addr;
  logic [31:0] read_data;
  logic        busy;
  logic        done;
  logic        error;

  logic [31:0] mem [0:127];
  logic        flip;
  int          n_cmp;
  int          n_bad;
  logic [38:0] wq[$];
  logic        dq[$];

  instruction_loader dut (
    .clk(clk), .rst_all(rst_all), .start(start), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .we(we), .write_addr(write_addr), .write_data(write_data),
    .read_addr(read_addr), .read_data(read_data),
    .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous write, combinational read with optional bit-0 corruption of word 2
  always @(posedge clk) begin
    if (we) mem[write_addr] <= write_data;
  end
  assign read_data = mem[read_addr] ^ {31'd0, (flip && (read_addr == 7'd2))};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write and every done pulse must match the head of its queue
  always @(negedge clk) begin
    if (rst_all) begin
      if (we) begin
        if (wq.size() == 0) begin
          check("unexpected_write", {25'd0, write_addr}, 32'hFFFF_FFFF);
        end else begin
          logic [38:0] e;
          e = wq.pop_front();
          check("write_addr", {25'd0, write_addr}, {25'd0, e[38:32]});
          check("write_data", write_data, e[31:0]);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic ee;
          ee = dq.pop_front();
          check("error_at_done", {31'd0, error}, {31'd0, ee});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input int cnt);
`ifdef LOADER_VERIFY_EN
    return 1 + cnt;
`else
    return 1 + 0 * cnt;
`endif
  endfunction

  task automatic wait_done(input int exp);
    int lat;
    lat = 0;
    while (!done && lat < 400) begin
      tick();
      lat++;
    end
    check("done_latency", 32'(lat), 32'(exp));
  endtask

  task automatic run_load(input int cnt, input logic [31:0] base, input bit gaps, input bit exp_err);
    start = 1'b1;
    word_count = 8'(cnt);
    tick();
    start = 1'b0;
    check("busy_in_load", {31'd0, busy}, 32'd1);
    check("error_cleared", {31'd0, error}, 32'd0);
    for (int i = 0; i < cnt; i++) begin
      in_valid = 1'b1;
      in_data = base + 32'(i);
      wq.push_back({7'(i), base + 32'(i)});
      tick();
      if (gaps && i != cnt - 1) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid = 1'b0;
    check("in_ready_after_last", {31'd0, in_ready}, 32'd0);
    dq.push_back(exp_err);
    wait_done(exp_lat(cnt));
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("writes_drained", 32'(wq.size()), 32'd0);
  endtask

  task automatic run_illegal(input logic [7:0] cnt);
    start = 1'b1;
    word_count = cnt;
    in_valid = 1'b1;
    in_data = 32'hDEAD_BEEF;
    dq.push_back(1'b1);
    tick();
    start = 1'b0;
    check("illegal_not_busy", {31'd0, busy}, 32'd0);
    check("illegal_no_ready", {31'd0, in_ready}, 32'd0);
    wait_done(0);
    tick();
    in_valid = 1'b0;
    check("illegal_error_sticky", {31'd0, error}, 32'd1);
    check("illegal_done_once", {31'd0, done}, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    flip = 1'b0;
    rst_all = 1'b0;
    start = 1'b0;
    word_count = 8'd0;
    in_valid = 1'b0;
    in_data = 32'd0;
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    tick();
    tick();
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_read_addr", {25'd0, read_addr}, 32'd0);
    rst_all = 1'b1;
    tick();

    // Reset in the middle of a load after two of four words
    start = 1'b1;
    word_count = 8'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = 32'h1111_0000 + 32'(i);
      wq.push_back({7'(i), 32'h1111_0000 + 32'(i)});
      tick();
    end
    rst_all = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_we", {31'd0, we}, 32'd0);
    check("midrst_write_addr", {25'd0, write_addr}, 32'd0);
    check("midrst_write_data", write_data, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    wq.delete();
    tick();
    rst_all = 1'b1;
    tick();

    // Four words streamed back to back
    run_load(4, 32'hA000_0000, 1'b0, 1'b0);
    check("mem_word2", mem[2], 32'hA000_0002);
`ifndef LOADER_VERIFY_EN
    check("read_addr_idle", {25'd0, read_addr}, 32'd0);
`endif

    // Three words with idle gaps between transfers
    run_load(3, 32'hB000_0010, 1'b1, 1'b0);

    // Full-depth load
    run_load(128, 32'h5A00_0000, 1'b0, 1'b0);
    check("mem_word127", mem[127], 32'h5A00_007F);

    // Illegal counts, then a legal start clears the error
    run_illegal(8'd0);
    run_illegal(8'd129);
    run_load(2, 32'h0000_00F0, 1'b0, 1'b0);

`ifdef LOADER_VERIFY_EN
    flip = 1'b1;
    run_load(4, 32'hC0DE_0000, 1'b0, 1'b1);
    flip = 1'b0;
    run_load(4, 32'hC0DE_0100, 1'b0, 1'b0);
`endif

    tick();
    check("final_queues_empty", 32'(wq.size() + dq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
